// File: rtl/hms_sync_ctrl.sv
// Purpose: debounces mode/position/increment buttons and runs the CLOCK/SETUP/ALARM-SET
//          controller, issuing one-cycle increment enables to the time and alarm counters.
// Latency: all outputs registered; press pulse 1 cycle after 2nd low sample, effect 1 cycle later.
// Backpressure: none; presses and ticks are consumed the cycle they occur.
//
// Ports:
//   clk, rst_n                 system clock, async active-low reset
//   i_sw0/i_sw1/i_sw2          raw buttons (active-low): mode, position, increment/alarm-enable
//   i_sec_at_max/i_min_at_max  carry levels from the seconds/minutes counters
//   i_alarm_match              time equals alarm setting (level)
//   o_mode, o_position         current mode and selected digit pair
//   o_time_inc, o_alarm_inc    {hour,min,sec} increment pulses
//   o_alarm_en, o_alarm_ring   alarm armed / sounding
//   o_blink_mask               digit-pair enables, 1 = lit
module hms_sync_ctrl #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int DEB_HZ    = 100,
  parameter int TIMEOUT_S = 30,
  parameter int RING_S    = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw0,
  input  logic       i_sw1,
  input  logic       i_sw2,
  input  logic       i_sec_at_max,
  input  logic       i_min_at_max,
  input  logic       i_alarm_match,
  output logic [1:0] o_mode,
  output logic [1:0] o_position,
  output logic [2:0] o_time_inc,
  output logic [2:0] o_alarm_inc,
  output logic       o_alarm_en,
  output logic       o_alarm_ring,
  output logic [5:0] o_blink_mask
);

  localparam int SAMP_DIV = CLK_HZ / DEB_HZ;
  localparam int HALF_DIV = CLK_HZ / 2;
  localparam int TW = $clog2(CLK_HZ);
  localparam int SW = $clog2(SAMP_DIV);
  localparam int BW = $clog2(HALF_DIV);
  localparam int OW = $clog2(TIMEOUT_S + 1);
  localparam int RW = $clog2(RING_S + 1);

  localparam logic [1:0] POS_SEC  = 2'd0;
  localparam logic [1:0] POS_MIN  = 2'd1;
  localparam logic [1:0] POS_HOUR = 2'd2;

  typedef enum logic [1:0] {
    M_CLOCK = 2'd0,
    M_SETUP = 2'd1,
    M_ASET  = 2'd2
  } mode_t;

  // ---------------- free-running time base ----------------
  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] samp_cnt;
  logic [BW-1:0] blink_cnt;
  logic          tick1, samp, phase_q, phase_d;

  assign tick1   = (tick_cnt == TW'(CLK_HZ - 1));
  assign samp    = (samp_cnt == SW'(SAMP_DIV - 1));
  assign phase_d = phase_q ^ (blink_cnt == BW'(HALF_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      samp_cnt  <= '0;
      blink_cnt <= '0;
      phase_q   <= 1'b0;
    end else begin
      tick_cnt  <= tick1 ? '0 : tick_cnt + TW'(1);
      samp_cnt  <= samp ? '0 : samp_cnt + SW'(1);
      blink_cnt <= (blink_cnt == BW'(HALF_DIV - 1)) ? '0 : blink_cnt + BW'(1);
      phase_q   <= phase_d;
    end
  end

  // ---------------- debounce ----------------
  // h0 is the newest sample, h1 the one before; deb is the debounced level (1 = released).
  logic [2:0] raw_sw, h0, h1, deb, press;
  logic       p0, p1, p2, any_press;

  assign raw_sw    = {i_sw2, i_sw1, i_sw0};
  assign press     = ~h0 & ~h1 & deb;
  assign p0        = press[0];
  assign p1        = press[1] & ~press[0];
  assign p2        = press[2] & ~press[1] & ~press[0];
  assign any_press = |press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h0  <= 3'b111;
      h1  <= 3'b111;
      deb <= 3'b111;
    end else begin
      if (samp) begin
        h1 <= h0;
        h0 <= raw_sw;
      end
      // A press drops deb so a held button pulses once; two high samples re-arm it.
      deb <= (deb & ~press) | (h0 & h1);
    end
  end

  // ---------------- controller ----------------
  mode_t         mode_q, mode_d;
  logic [1:0]    pos_q, pos_d, pos_next;
  logic          en_q, en_d, ring_q, ring_d, match_q;
  logic [OW-1:0] to_q, to_d;
  logic [RW-1:0] rc_q, rc_d;
  logic [2:0]    tinc_q, tinc_d, ainc_q, ainc_d;
  logic [5:0]    mask_q, mask_d;

  assign pos_next = (pos_q == POS_HOUR) ? POS_SEC : pos_q + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= M_CLOCK;
      pos_q   <= POS_SEC;
      en_q    <= 1'b0;
      ring_q  <= 1'b0;
      match_q <= 1'b0;
      to_q    <= '0;
      rc_q    <= '0;
      tinc_q  <= 3'b000;
      ainc_q  <= 3'b000;
      mask_q  <= 6'b111111;
    end else begin
      mode_q  <= mode_d;
      pos_q   <= pos_d;
      en_q    <= en_d;
      ring_q  <= ring_d;
      match_q <= i_alarm_match;
      to_q    <= to_d;
      rc_q    <= rc_d;
      tinc_q  <= tinc_d;
      ainc_q  <= ainc_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    pos_d  = pos_q;
    en_d   = en_q;
    ring_d = ring_q;
    rc_d   = rc_q;
    to_d   = to_q;
    tinc_d = 3'b000;
    ainc_d = 3'b000;
    mask_d = 6'b111111;

    // Normal timekeeping: carries are resolved here so all three enables land together.
    if (mode_q == M_CLOCK && tick1)
      tinc_d = {i_sec_at_max & i_min_at_max, i_sec_at_max, 1'b1};

    if (ring_q && tick1) begin
      if (rc_q == RW'(RING_S - 1)) begin
        ring_d = 1'b0;
        rc_d   = '0;
      end else begin
        rc_d = rc_q + RW'(1);
      end
    end

    // Edge-triggered so a match level that outlives the ring cannot restart it.
    if (mode_q == M_CLOCK && en_q && i_alarm_match && !match_q) begin
      ring_d = 1'b1;
      rc_d   = '0;
    end

    if (mode_q != M_CLOCK) begin
      if (any_press) begin
        to_d = '0;
      end else if (tick1) begin
        if (to_q == OW'(TIMEOUT_S - 1)) begin
          mode_d = M_CLOCK;
          pos_d  = POS_SEC;
        end else begin
          to_d = to_q + OW'(1);
        end
      end
    end

    // A press that silences the ring is swallowed.
    if (ring_q && any_press) begin
      ring_d = 1'b0;
      rc_d   = '0;
    end else if (p0) begin
      case (mode_q)
        M_CLOCK: mode_d = M_SETUP;
        M_SETUP: mode_d = M_ASET;
        default: mode_d = M_CLOCK;
      endcase
      pos_d = POS_SEC;
    end else if (p1) begin
      if (mode_q != M_CLOCK) pos_d = pos_next;
    end else if (p2) begin
      case (mode_q)
        M_SETUP: tinc_d = 3'b001 << pos_q;
        M_ASET:  ainc_d = 3'b001 << pos_q;
        default: en_d   = ~en_q;
      endcase
    end

    if (mode_d != mode_q) to_d = '0;

    if (mode_d != M_CLOCK || !en_d) begin
      ring_d = 1'b0;
      rc_d   = '0;
    end

    // Mask built from next-state values so it lines up with the registered mode/position.
    if (mode_d != M_CLOCK && phase_d) begin
      case (pos_d)
        POS_SEC:  mask_d[1:0] = 2'b00;
        POS_MIN:  mask_d[3:2] = 2'b00;
        POS_HOUR: mask_d[5:4] = 2'b00;
        default:  mask_d      = 6'b111111;
      endcase
    end
  end

  assign o_mode       = mode_q;
  assign o_position   = pos_q;
  assign o_time_inc   = tinc_q;
  assign o_alarm_inc  = ainc_q;
  assign o_alarm_en   = en_q;
  assign o_alarm_ring = ring_q;
  assign o_blink_mask = mask_q;

endmodule
